sign_extender: RTL and testbench

Width-extension unit for the processor datapath: widens a 16-bit immediate to a 32-bit operand. It provides an always-valid combinational 16→32 sign extension on `data_out`, used directly by the ALU operand mux. It also provides a registered, mode-selectable extension path (sign/zero, byte/halfword) with a valid flag, used by the load/immediate pipeline stage.

---
 rtl/sign_extender.sv | 70 +++++++
 tb/tb_sign_extender.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sign_extender.sv
// rtl/sign_extender.sv - 16-to-32 bit width extension: combinational sign16 plus registered mode-selectable path
module sign_extender #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  data_in,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [OUT_W-1:0] data_out,
    output logic [OUT_W-1:0] data_q,
    output logic             out_valid,
    output logic             neg_q
);

    // Mode encodings for the registered path
    localparam logic [1:0] MODE_SIGN16 = 2'b00;
    localparam logic [1:0] MODE_ZERO16 = 2'b01;
    localparam logic [1:0] MODE_SIGN8  = 2'b10;
    localparam logic [1:0] MODE_ZERO8  = 2'b11;

    localparam int HI16_W = OUT_W - IN_W;
    localparam int HI8_W  = OUT_W - 8;

    logic [OUT_W-1:0] w_sign16;
    logic [OUT_W-1:0] w_ext;

    logic [OUT_W-1:0] r_data_q;
    logic             r_out_valid;
    logic             r_neg_q;

    // Halfword sign extension shared by the ALU operand path and the sign16 mode
    assign w_sign16 = {{HI16_W{data_in[IN_W-1]}}, data_in};

    // Combinational operand path: independent of mode, clock and reset
    assign data_out = w_sign16;

    // Mode-selected extension feeding the capture register; byte modes ignore the upper input byte
    always_comb begin
        w_ext = '0;
        case (mode)
            MODE_SIGN16: w_ext = w_sign16;
            MODE_ZERO16: w_ext = {{HI16_W{1'b0}}, data_in};
            MODE_SIGN8:  w_ext = {{HI8_W{data_in[7]}}, data_in[7:0]};
            MODE_ZERO8:  w_ext = {{HI8_W{1'b0}}, data_in[7:0]};
            default:     w_ext = '0;
        endcase
    end

    // Capture register: load on in_valid, hold otherwise; out_valid pulses one cycle per accepted input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q    <= '0;
            r_neg_q     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_data_q <= w_ext;
                r_neg_q  <= w_ext[OUT_W-1];
            end
        end
    end

    assign data_q    = r_data_q;
    assign out_valid = r_out_valid;
    assign neg_q     = r_neg_q;

endmodule

// File: tb/tb_sign_extender.sv
// tb/tb_sign_extender.sv - scoreboard bench for sign_extender with randomized and directed stimulus
module tb_sign_extender;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic [1:0]  mode;
    logic        in_valid;
    logic [31:0] data_out;
    logic [31:0] data_q;
    logic        out_valid;
    logic        neg_q;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb[$];
    logic [31:0] mon_e;

    always #5 clk = ~clk;

    sign_extender #(.IN_W(16), .OUT_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .mode     (mode),
        .in_valid (in_valid),
        .data_out (data_out),
        .data_q   (data_q),
        .out_valid(out_valid),
        .neg_q    (neg_q)
    );

    // Reference: extension as signed/unsigned integer arithmetic on the chosen field
    function automatic logic [31:0] ref_ext(logic [15:0] d, logic [1:0] m);
        int u16, u8, v;
        u16 = int'(d);
        u8  = u16 % 256;
        case (m)
            2'd0:    v = (u16 >= 32768) ? u16 - 65536 : u16;
            2'd1:    v = u16;
            2'd2:    v = (u8 >= 128) ? u8 - 256 : u8;
            default: v = u8;
        endcase
        return 32'(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented output is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: got data_q %h expected no output at %0t", data_q, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("data_q", data_q, mon_e);
                chk("neg_q", {31'b0, neg_q}, {31'b0, mon_e[31]});
            end
        end
    end

    // Drive one cycle of inputs; valid inputs push their expected result
    task automatic cycle(logic [15:0] d, logic [1:0] m, logic v, logic [31:0] e);
        @(posedge clk);
        #1;
        data_in  = d;
        mode     = m;
        in_valid = v;
        if (v) sb.push_back(e);
        #1;
        chk("data_out_track", data_out, ref_ext(d, 2'd0));
    endtask

    task automatic rcycle(logic [15:0] d, logic [1:0] m, logic v);
        cycle(d, m, v, ref_ext(d, m));
    endtask

    logic [15:0] comb_in  [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'hFFFF, 16'h8000};
    logic [31:0] comb_exp [5] = '{32'h00000000, 32'h00000001, 32'h00007FFF, 32'hFFFFFFFF, 32'hFFFF8000};
    logic [15:0] edge_in  [9] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF,
                                  16'h007F, 16'h0080, 16'hFF80, 16'h00FF};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        data_in  = 16'h0;
        mode     = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_data_q", data_q, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_neg_q", {31'b0, neg_q}, 32'h0);

        for (int i = 0; i < 5; i++) begin
            data_in = comb_in[i];
            #5;
            chk("comb_data_out", data_out, comb_exp[i]);
            chk("comb_signed", data_out, ref_ext(comb_in[i], 2'd0));
        end

        @(negedge clk);
        rst_n = 1'b1;

        cycle(16'h8001, 2'd0, 1'b1, 32'hFFFF8001);
        cycle(16'h8001, 2'd1, 1'b1, 32'h00008001);
        cycle(16'h1280, 2'd2, 1'b1, 32'hFFFFFF80);
        cycle(16'h1280, 2'd3, 1'b1, 32'h00000080);
        cycle(16'hFF7F, 2'd2, 1'b1, 32'h0000007F);
        cycle(16'h0001, 2'd0, 1'b1, 32'h00000001);
        cycle(16'hFFFE, 2'd0, 1'b1, 32'hFFFFFFFE);
        cycle(16'hAAAA, 2'd1, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        chk("idle_out_valid", {31'b0, out_valid}, 32'h0);
        chk("idle_hold_data_q", data_q, 32'hFFFFFFFE);
        chk("idle_hold_neg_q", {31'b0, neg_q}, 32'h1);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] d;
            d = ($urandom % 3 == 0) ? edge_in[$urandom % 9] : 16'($urandom);
            rcycle(d, 2'($urandom % 4), ($urandom % 4) != 0);
        end

        rcycle(16'h8001, 2'd0, 1'b1);
        rcycle(16'h1234, 2'd0, 1'b1);
        @(negedge clk);
        #1;
        chk("pre_rst_out_valid", {31'b0, out_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_data_q", data_q, 32'h0);
        chk("async_rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_neg_q", {31'b0, neg_q}, 32'h0);
        sb.delete();
        for (int i = 0; i < 9; i++) begin
            data_in = edge_in[i];
            #1;
            chk("rst_data_out_track", data_out, ref_ext(edge_in[i], 2'd0));
        end
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_hold_data_q", data_q, 32'h0);
        chk("rst_hold_out_valid", {31'b0, out_valid}, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++)
            rcycle(16'($urandom), 2'($urandom % 4), 1'b1);
        rcycle(16'h0, 2'd0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
